nandy_control_decoder: RTL and testbench

- Instruction decoder for the Nandy CPU.
- Maps the current 8-bit opcode, the two-phase cycle flag and the carry flag to every datapath and sequencing strobe: memory, jump, register-file, ALU-op and signal lines.
- Decode is purely combinational; the clock and reset ports exist for integration uniformity and the safe-state override.

---
 rtl/nandy_control_decoder.sv | 135 +++++++++++++
 tb/tb_nandy_control_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nandy_control_decoder.sv
// Purpose : Nandy CPU instruction decoder; opcode + phase + carry -> datapath/sequencing strobes.
// Latency : zero; purely combinational from inst/cycle/carry, rst forces all outputs low asynchronously.
// Backpr. : none; outputs follow inputs continuously, no handshake.
//
// Ports:
//   clk            clock (unused by decode, present for integration uniformity)
//   rst            async active-high reset, holds every output at 0 while high
//   inst[7:0]      current opcode (i7..i0)
//   cycle          execution phase (0 = first, 1 = second)
//   carry          current carry flag
//   M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,WA,ISP,WC   single-bit strobes
//   RS[1:0]        register select
//   ALU[3:0]       ALU opcode
//   SIG[7:0]       one-hot signal strobes
module nandy_control_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       cycle,
    input  logic       carry,
    output logic       M,
    output logic       S,
    output logic       J,
    output logic       LJ,
    output logic       CLI,
    output logic       LJR,
    output logic       MW,
    output logic       MC,
    output logic       RD,
    output logic       WR,
    output logic       Y,
    output logic [1:0] RS,
    output logic       WA,
    output logic       ISP,
    output logic       WC,
    output logic [3:0] ALU,
    output logic [7:0] SIG
);

    // All decoded strobes travel together so the reset override is a single mux.
    typedef struct packed {
        logic       m;
        logic       s;
        logic       j;
        logic       lj;
        logic       cli;
        logic       ljr;
        logic       mw;
        logic       mc;
        logic       rd;
        logic       wr;
        logic       y;
        logic [1:0] rs;
        logic       wa;
        logic       isp;
        logic       wc;
        logic [3:0] alu;
        logic [7:0] sig;
    } ctl_t;

    // Clock is deliberately unused: there is no state in this block.
    logic w_unused_clk;
    assign w_unused_clk = clk;

    logic w_i7, w_i6, w_i5, w_i4, w_i3, w_i2, w_i1;
    assign w_i7 = inst[7];
    assign w_i6 = inst[6];
    assign w_i5 = inst[5];
    assign w_i4 = inst[4];
    assign w_i3 = inst[3];
    assign w_i2 = inst[2];
    assign w_i1 = inst[1];

    // Z: opcode row 0x0X (I/O group). A: accumulator-writing ALU group,
    // which in the second phase also includes the 0xC0-0xDF row.
    logic w_z;
    logic w_a;
    assign w_z = ~w_i7 & ~w_i6 & ~w_i5 & ~w_i4;
    assign w_a = (w_i6 & ~w_i7) | (cycle & w_i6 & ~w_i5);

    ctl_t w_dec;
    ctl_t w_out;

    always_comb begin
        w_dec      = '0;
        w_dec.m    = w_i7 & ~w_i6 & cycle;
        w_dec.s    = w_i4;
        // i4 turns the jump into "jump if no carry"; otherwise unconditional.
        w_dec.j    = w_i7 & w_i6 & w_i5 & cycle & ~(carry & w_i4);
        w_dec.lj   = ~w_i7 & ~w_i6 & ~w_i5 & w_i4 & ~w_i3;
        w_dec.cli  = w_dec.lj & w_i1;
        w_dec.ljr  = w_dec.lj & w_i2;
        w_dec.mw   = w_dec.m & w_i5;
        w_dec.mc   = w_i7 & ~cycle;
        // RD and WR are independent; both may assert together.
        w_dec.rd   = w_z & w_i2;
        w_dec.wr   = w_z & w_i3;
        w_dec.y    = w_i5;
        w_dec.rs   = inst[1:0];
        // Memory loads write the accumulator; ALU ops do too except the
        // i4=1/i3=0 sub-group which only updates carry.
        w_dec.wa   = (w_dec.m & ~w_i5) | (w_a & ~(w_i4 & ~w_i3));
        w_dec.isp  = ~w_i7 & ~w_i6 & w_i5;
        w_dec.wc   = (w_a | w_dec.isp) & w_i4;
        // Non-ALU opcodes still present a fixed ALU code: 8 for
        // non-memory ops, 0 (pass-through) for memory ops.
        w_dec.alu  = w_i6 ? inst[3:0] : {~w_i7, 3'b000};
        // Signal group 0x18-0x1F: one-hot strobe selected by i[2:0].
        if (~w_i7 & ~w_i6 & ~w_i5 & w_i4 & w_i3) begin
            w_dec.sig = 8'h01 << inst[2:0];
        end
    end

    // Asynchronous override: no clock edge needed to enter or leave reset.
    assign w_out = rst ? '0 : w_dec;

    assign M   = w_out.m;
    assign S   = w_out.s;
    assign J   = w_out.j;
    assign LJ  = w_out.lj;
    assign CLI = w_out.cli;
    assign LJR = w_out.ljr;
    assign MW  = w_out.mw;
    assign MC  = w_out.mc;
    assign RD  = w_out.rd;
    assign WR  = w_out.wr;
    assign Y   = w_out.y;
    assign RS  = w_out.rs;
    assign WA  = w_out.wa;
    assign ISP = w_out.isp;
    assign WC  = w_out.wc;
    assign ALU = w_out.alu;
    assign SIG = w_out.sig;

endmodule

// File: tb/tb_nandy_control_decoder.sv
// Purpose : self-checking bench for nandy_control_decoder (scoreboard + opcode-map reference model).
// Latency : each vector is applied after a rising edge and observed on the following falling edge.
// Backpr. : none; the bench throttles itself to one vector per clock.
module tb_nandy_control_decoder;

    typedef struct packed {
        logic       m;
        logic       s;
        logic       j;
        logic       lj;
        logic       cli;
        logic       ljr;
        logic       mw;
        logic       mc;
        logic       rd;
        logic       wr;
        logic       y;
        logic [1:0] rs;
        logic       wa;
        logic       isp;
        logic       wc;
        logic [3:0] alu;
        logic [7:0] sig;
    } obs_t;

    typedef struct packed {
        logic [7:0] inst;
        logic       cycle;
        logic       carry;
        logic       rst;
        obs_t       exp;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [7:0] inst;
    logic       cycle;
    logic       carry;
    logic       M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] SIG;

    sb_t  sb_q[$];
    logic obs_vld;
    int   n_checks;
    int   n_fail;

    nandy_control_decoder dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst),
        .cycle(cycle),
        .carry(carry),
        .M    (M),
        .S    (S),
        .J    (J),
        .LJ   (LJ),
        .CLI  (CLI),
        .LJR  (LJR),
        .MW   (MW),
        .MC   (MC),
        .RD   (RD),
        .WR   (WR),
        .Y    (Y),
        .RS   (RS),
        .WA   (WA),
        .ISP  (ISP),
        .WC   (WC),
        .ALU  (ALU),
        .SIG  (SIG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: works from the opcode map (address ranges and bit
    // tests on the opcode value), not from gate equations.
    function automatic obs_t model(input logic [7:0] op, input logic cyc,
                                   input logic cy, input logic r);
        obs_t o;
        int   v;
        bit   in_alu_grp;
        bit   in_isp_grp;
        o = '0;
        if (r) return o;
        v = int'(op);
        o.s   = (v % 32) >= 16;
        o.y   = (v % 64) >= 32;
        o.rs  = 2'(v % 4);
        // 0x80-0xBF: memory instructions
        o.m   = (v >= 8'h80 && v < 8'hC0) && cyc;
        o.mw  = o.m && v >= 8'hA0;
        o.mc  = (v >= 8'h80) && !cyc;
        // 0xE0-0xFF: jumps; 0xF0-0xFF are conditional on no carry
        o.j   = (v >= 8'hE0) && cyc && !(v >= 8'hF0 && cy);
        // 0x10-0x17: link/jump group
        o.lj  = (v >= 8'h10 && v < 8'h18);
        o.cli = o.lj && ((v / 2) % 2 == 1);
        o.ljr = o.lj && ((v / 4) % 2 == 1);
        // 0x00-0x0F: I/O
        o.rd  = (v < 8'h10) && ((v / 4) % 2 == 1);
        o.wr  = (v < 8'h10) && ((v / 8) % 2 == 1);
        // 0x20-0x3F: stack pointer group
        in_isp_grp = (v >= 8'h20 && v < 8'h40);
        o.isp = in_isp_grp;
        // 0x40-0x7F always, and 0xC0-0xDF in the second phase
        in_alu_grp = (v >= 8'h40 && v < 8'h80) || (cyc && v >= 8'hC0 && v < 8'hE0);
        o.wa  = (o.m && v < 8'hA0) ||
                (in_alu_grp && !((v % 32) >= 16 && (v % 16) < 8));
        o.wc  = (in_alu_grp || in_isp_grp) && o.s;
        if ((v / 64) % 2 == 1) o.alu = 4'(v % 16);
        else if (v < 8'h80)    o.alu = 4'd8;
        else                   o.alu = 4'd0;
        if (v >= 8'h18 && v < 8'h20) o.sig = 8'(1 << (v - 8'h18));
        return o;
    endfunction

    task automatic apply(input logic [7:0] op, input logic cyc,
                         input logic cy, input logic r);
        sb_t e;
        @(posedge clk);
        #1;
        inst  = op;
        cycle = cyc;
        carry = cy;
        rst   = r;
        e.inst  = op;
        e.cycle = cyc;
        e.carry = cy;
        e.rst   = r;
        e.exp   = model(op, cyc, cy, r);
        sb_q.push_back(e);
        obs_vld = 1'b1;
    endtask

    // Monitor: observes the DUT on the falling edge and retires one entry.
    always @(negedge clk) begin
        if (obs_vld) begin
            obs_t got;
            sb_t  e;
            got = {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, RS, WA, ISP, WC, ALU, SIG};
            n_checks = n_checks + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL scoreboard_underflow got=%h required=<queued entry>", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL decode inst=%02h cycle=%b carry=%b rst=%b got=%07h required=%07h",
                             e.inst, e.cycle, e.carry, e.rst, got, e.exp);
                end
            end
        end
    end

    // Immediate asynchronous reset check, made directly without a clock edge.
    task automatic check_now(input string name, input logic r);
        obs_t got;
        obs_t exp;
        #1;
        got = {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, RS, WA, ISP, WC, ALU, SIG};
        exp = model(inst, cycle, carry, r);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%07h required=%07h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        obs_vld  = 1'b0;
        rst      = 1'b1;
        inst     = 8'hFF;
        cycle    = 1'b1;
        carry    = 1'b1;

        // Reset state with an opcode that would otherwise decode many strobes.
        apply(8'hFF, 1'b1, 1'b0, 1'b1);
        apply(8'h80, 1'b1, 1'b0, 1'b1);

        // Directed vectors from the opcode map.
        apply(8'h00, 1'b0, 1'b0, 1'b0);
        apply(8'h1B, 1'b0, 1'b0, 1'b0);
        apply(8'h12, 1'b0, 1'b0, 1'b0);
        apply(8'hF0, 1'b1, 1'b0, 1'b0);
        apply(8'hF0, 1'b1, 1'b1, 1'b0);
        apply(8'hE0, 1'b1, 1'b1, 1'b0);
        apply(8'h80, 1'b1, 1'b0, 1'b0);
        apply(8'h80, 1'b0, 1'b0, 1'b0);
        apply(8'hA0, 1'b1, 1'b0, 1'b0);
        apply(8'h5C, 1'b0, 1'b0, 1'b0);
        apply(8'h2C, 1'b0, 1'b0, 1'b0);
        apply(8'h0C, 1'b0, 1'b0, 1'b0);
        apply(8'hC5, 1'b1, 1'b0, 1'b0);
        apply(8'hC5, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep of all {inst, cycle, carry}.
        for (int k = 0; k < 1024; k++) begin
            apply(8'(k >> 2), k[1], k[0], 1'b0);
        end

        // Randomized vectors with occasional reset pulses.
        for (int k = 0; k < 300; k++) begin
            apply(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Reset asserted mid-vector between clock edges: outputs drop at once,
        // and come back on release without any clock edge.
        @(posedge clk);
        obs_vld = 1'b0;
        #2;
        inst  = 8'h5C;
        cycle = 1'b0;
        carry = 1'b0;
        rst   = 1'b0;
        check_now("pre_reset_decode", 1'b0);
        rst = 1'b1;
        check_now("async_reset_assert", 1'b1);
        rst = 1'b0;
        check_now("async_reset_release", 1'b0);
        inst = 8'h1F;
        rst  = 1'b1;
        check_now("async_reset_sig", 1'b1);
        rst  = 1'b0;
        check_now("async_release_sig", 1'b0);

        repeat (2) @(posedge clk);
        n_checks = n_checks + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
